// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared definitions for the block-RAM port arbiter and its
//                lane-alignment helper: access-size codes, response-owner
//                encoding and the misalignment rule.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // Access size codes carried on d_size; 2'b11 is reserved and is always
    // treated as a misaligned access.
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Which requester owns the response slot one cycle after a grant.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    // Halfwords need an even address, words need a 4-byte-aligned address,
    // and the reserved size code can never be serviced.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] off);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = off[0];
            SZ_W:    mis = (off != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_if
//  Description : Bundles the instruction-fetch port, the load/store port and
//                the block-RAM port of the memory arbiter.
//                slave  : arbiter view (requests in, grants/responses/RAM out)
//                master : environment view (core requesters plus the RAM)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) ();

    // Instruction fetch port
    logic                      if_req;
    logic [ADDRESS_WIDTH-1:0]  if_addr;
    logic                      if_gnt;
    logic                      if_rvalid;
    logic [DATA_WIDTH-1:0]     if_rdata;

    // Load/store port
    logic                      d_req;
    logic                      d_we;
    logic [1:0]                d_size;
    logic                      d_unsigned;
    logic [ADDRESS_WIDTH-1:0]  d_addr;
    logic [DATA_WIDTH-1:0]     d_wdata;
    logic                      d_gnt;
    logic                      d_rvalid;
    logic [DATA_WIDTH-1:0]     d_rdata;
    logic                      d_err;

    // Block-RAM port
    logic [ADDRESS_WIDTH-1:0]  ram_addr;
    logic [DATA_WIDTH/8-1:0]   ram_be;
    logic [DATA_WIDTH-1:0]     ram_data_in;
    logic                      ram_we;
    logic [DATA_WIDTH-1:0]     ram_data_out;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output ram_addr, ram_be, ram_data_in, ram_we,
        input  ram_data_out
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  ram_addr, ram_be, ram_data_in, ram_we,
        output ram_data_out
    );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_align
//  Description : Purely combinational lane logic for a 32-bit, 4-lane RAM.
//                Store side: replicates sub-word data to every lane and
//                produces byte enables. Load side: extracts the addressed
//                byte/half from a RAM word and sign- or zero-extends it.
//  Ports       : st_size_i/st_off_i/st_wdata_i -> st_be_o, st_data_o
//                ld_size_i/ld_off_i/ld_unsigned_i/ld_raw_i -> ld_data_o
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import mem_pkg::*;
(
    input  logic [1:0]  st_size_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_wdata_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_data_o,

    input  logic [1:0]  ld_size_i,
    input  logic [1:0]  ld_off_i,
    input  logic        ld_unsigned_i,
    input  logic [31:0] ld_raw_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;

    // Replicating the data means the RAM sees the right value on whichever
    // lane the enables select, so no shifter is needed on the write path.
    always_comb begin
        st_be_o   = 4'b0000;
        st_data_o = st_wdata_i;
        case (st_size_i)
            SZ_B: begin
                st_data_o = {4{st_wdata_i[7:0]}};
                st_be_o   = 4'b0001 << st_off_i;
            end
            SZ_H: begin
                st_data_o = {2{st_wdata_i[15:0]}};
                st_be_o   = st_off_i[1] ? 4'b1100 : 4'b0011;
            end
            SZ_W: begin
                st_be_o   = 4'b1111;
            end
            default: begin
                st_be_o   = 4'b0000;
            end
        endcase
    end

    always_comb begin
        case (ld_off_i)
            2'd0:    w_ld_byte = ld_raw_i[7:0];
            2'd1:    w_ld_byte = ld_raw_i[15:8];
            2'd2:    w_ld_byte = ld_raw_i[23:16];
            default: w_ld_byte = ld_raw_i[31:24];
        endcase
        w_ld_half = ld_off_i[1] ? ld_raw_i[31:16] : ld_raw_i[15:0];
    end

    always_comb begin
        case (ld_size_i)
            SZ_B: ld_data_o = ld_unsigned_i ? {24'd0, w_ld_byte}
                                            : {{24{w_ld_byte[7]}}, w_ld_byte};
            SZ_H: ld_data_o = ld_unsigned_i ? {16'd0, w_ld_half}
                                            : {{16{w_ld_half[15]}}, w_ld_half};
            default: ld_data_o = ld_raw_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-port block RAM between instruction fetch
//                and the load/store unit. Data requests have priority, but
//                after STARVE_LIMIT consecutive data grants with fetch
//                waiting, fetch is served. One RAM access per cycle; the
//                response (rvalid + aligned data) follows one cycle after
//                the grant.
//  Ports       : clk, rst_n (async, active low)
//                bus.slave : fetch port (if_*), load/store port (d_*),
//                            RAM port (ram_*)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,   // only 32 (4 byte lanes) is supported
    parameter int STARVE_LIMIT  = 4     // must fit the 3-bit starve counter
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);

    localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

    // Starve counter and response-stage registers
    logic [2:0]  starve_q, starve_d;
    owner_e      owner_q,  owner_d;
    logic [1:0]  off_q,    off_d;
    logic [1:0]  size_q,   size_d;
    logic        uns_q,    uns_d;
    logic        err_q,    err_d;

    logic                   w_d_misal;
    logic                   w_if_wins;
    logic                   w_if_gnt;
    logic                   w_d_gnt;
    logic [3:0]             w_st_be;
    logic [DATA_WIDTH-1:0]  w_st_data;
    logic [DATA_WIDTH-1:0]  w_ld_data;

    assign w_d_misal = is_misaligned(bus.d_size, bus.d_addr[1:0]);

    // Fetch wins when it is the only requester, or when data has held the
    // port for STARVE_LIMIT grants in a row while fetch was waiting.
    assign w_if_wins = bus.if_req && (!bus.d_req || (starve_q >= STARVE_MAX));

    // Grants are gated by rst_n so nothing reaches the RAM during reset.
    assign w_if_gnt  = rst_n && w_if_wins;
    assign w_d_gnt   = rst_n && bus.d_req && !w_if_wins;

    assign bus.if_gnt = w_if_gnt;
    assign bus.d_gnt  = w_d_gnt;

    lsu_align u_align (
        .st_size_i     (bus.d_size),
        .st_off_i      (bus.d_addr[1:0]),
        .st_wdata_i    (bus.d_wdata),
        .st_be_o       (w_st_be),
        .st_data_o     (w_st_data),
        .ld_size_i     (size_q),
        .ld_off_i      (off_q),
        .ld_unsigned_i (uns_q),
        .ld_raw_i      (bus.ram_data_out),
        .ld_data_o     (w_ld_data)
    );

    // RAM drive: the granted request goes straight to the RAM this cycle.
    // A misaligned data request is granted but produces no RAM access.
    always_comb begin
        bus.ram_addr    = '0;
        bus.ram_be      = '0;
        bus.ram_data_in = '0;
        bus.ram_we      = 1'b0;
        if (w_if_gnt) begin
            bus.ram_addr = {bus.if_addr[ADDRESS_WIDTH-1:2], 2'b00};
            bus.ram_be   = 4'b1111;
        end else if (w_d_gnt && !w_d_misal) begin
            bus.ram_addr = {bus.d_addr[ADDRESS_WIDTH-1:2], 2'b00};
            bus.ram_be   = w_st_be;
            bus.ram_we   = bus.d_we;
            if (bus.d_we) begin
                bus.ram_data_in = w_st_data;
            end
        end
    end

    // Starve counter: counts data grants only while fetch is waiting.
    always_comb begin
        starve_d = starve_q;
        if (!bus.if_req || w_if_gnt) begin
            starve_d = 3'd0;
        end else if (w_d_gnt && (starve_q != 3'd7)) begin
            starve_d = starve_q + 3'd1;
        end
    end

    // Response stage: aligned stores complete at grant and need no slot;
    // loads and every misaligned access return a response next cycle.
    always_comb begin
        owner_d = OWN_NONE;
        off_d   = bus.d_addr[1:0];
        size_d  = bus.d_size;
        uns_d   = bus.d_unsigned;
        err_d   = 1'b0;
        if (w_if_gnt) begin
            owner_d = OWN_IF;
        end else if (w_d_gnt && (w_d_misal || !bus.d_we)) begin
            owner_d = OWN_D;
            err_d   = w_d_misal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= 3'd0;
            owner_q  <= OWN_NONE;
            off_q    <= 2'b00;
            size_q   <= SZ_B;
            uns_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            starve_q <= starve_d;
            owner_q  <= owner_d;
            off_q    <= off_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            err_q    <= err_d;
        end
    end

    // Read data is passed through from the RAM's registered output and is
    // forced to zero whenever the port has no valid response.
    assign bus.if_rvalid = (owner_q == OWN_IF);
    assign bus.if_rdata  = bus.if_rvalid ? bus.ram_data_out : '0;

    assign bus.d_rvalid  = (owner_q == OWN_D);
    assign bus.d_err     = bus.d_rvalid && err_q;
    assign bus.d_rdata   = (bus.d_rvalid && !err_q) ? w_ld_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter. Drivers issue
//                fetch and load/store requests; a monitor predicts grants,
//                RAM-port activity and responses from a byte-level memory
//                model and compares every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ram_fill = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_port_arbiter #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .STARVE_LIMIT  (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int n_if_gnt = 0;
    int n_d_gnt  = 0;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } resp_t;

    resp_t       ifq[$];
    resp_t       dq[$];
    logic [7:0]  mbytes [0:255];
    logic [31:0] ram    [0:63];
    int          starve_cnt = 0;

    function automatic logic [31:0] seed_word(input int i);
        return (32'h9E37_79B9 * 32'(i + 1)) ^ 32'(i * 131);
    endfunction

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endfunction

    // Little-endian byte read from the model, then extension.
    function automatic logic [31:0] model_load(input int a, input logic [1:0] sz,
                                               input logic uns);
        logic [31:0] v;
        case (sz)
            SZ_B: v = uns ? {24'd0, mbytes[a]} : {{24{mbytes[a][7]}}, mbytes[a]};
            SZ_H: v = uns ? {16'd0, mbytes[a+1], mbytes[a]}
                          : {{16{mbytes[a+1][7]}}, mbytes[a+1], mbytes[a]};
            default: v = {mbytes[a+3], mbytes[a+2], mbytes[a+1], mbytes[a]};
        endcase
        return v;
    endfunction

    // Block RAM: registered read, byte-enabled write (256 bytes).
    always @(posedge clk) begin
        if (ram_fill) begin
            for (int i = 0; i < 64; i++) ram[i] <= seed_word(i);
        end else if (bus.ram_we) begin
            for (int k = 0; k < 4; k++)
                if (bus.ram_be[k]) ram[bus.ram_addr[7:2]][8*k +: 8] <= bus.ram_data_in[8*k +: 8];
        end
        bus.ram_data_out <= ram[bus.ram_addr[7:2]];
    end

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    initial begin : monitor
        logic [31:0] w, ed;
        logic [3:0]  ebe;
        logic        exp_f, exp_d, mis;
        int          a, n;
        resp_t       e;
        for (int i = 0; i < 256; i++) begin
            w = seed_word(i / 4);
            mbytes[i] = w[8*(i%4) +: 8];
        end
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                chk("reset_ctrl", {22'd0, bus.if_gnt, bus.d_gnt, bus.ram_we, bus.if_rvalid,
                                   bus.d_rvalid, bus.d_err, bus.ram_be}, 32'd0);
                chk("reset_if_rdata", bus.if_rdata, 32'd0);
                chk("reset_d_rdata", bus.d_rdata, 32'd0);
                ifq.delete();
                dq.delete();
                starve_cnt = 0;
            end else begin
                // Responses due this cycle
                if (ifq.size() > 0 && ifq[0].due == cyc) begin
                    e = ifq.pop_front();
                    chk("if_rvalid", {31'd0, bus.if_rvalid}, 32'd1);
                    chk("if_rdata", bus.if_rdata, e.data);
                end else begin
                    chk("if_idle", {31'd0, bus.if_rvalid}, 32'd0);
                    chk("if_rdata_idle", bus.if_rdata, 32'd0);
                end
                if (dq.size() > 0 && dq[0].due == cyc) begin
                    e = dq.pop_front();
                    chk("d_rvalid", {31'd0, bus.d_rvalid}, 32'd1);
                    chk("d_err", {31'd0, bus.d_err}, {31'd0, e.err});
                    chk("d_rdata", bus.d_rdata, e.data);
                end else begin
                    chk("d_idle", {30'd0, bus.d_rvalid, bus.d_err}, 32'd0);
                    chk("d_rdata_idle", bus.d_rdata, 32'd0);
                end

                // Arbitration
                exp_f = bus.if_req && (!bus.d_req || starve_cnt >= 4);
                exp_d = bus.d_req && !exp_f;
                chk("if_gnt", {31'd0, bus.if_gnt}, {31'd0, exp_f});
                chk("d_gnt", {31'd0, bus.d_gnt}, {31'd0, exp_d});
                if (bus.if_gnt) n_if_gnt++;
                if (bus.d_gnt)  n_d_gnt++;
                if (!bus.if_req || exp_f) starve_cnt = 0;
                else if (exp_d)           starve_cnt++;

                // RAM port and expected responses
                if (exp_f) begin
                    chk("f_ram_addr", bus.ram_addr, {bus.if_addr[31:2], 2'b00});
                    chk("f_ram_ctl", {27'd0, bus.ram_we, bus.ram_be}, 32'h0000_000F);
                    ifq.push_back('{cyc + 1, model_load(int'(bus.if_addr[7:2]) * 4, SZ_W, 1'b0), 1'b0});
                end else if (exp_d) begin
                    a = int'(bus.d_addr[7:0]);
                    n = (bus.d_size == SZ_B) ? 1 : (bus.d_size == SZ_H) ? 2 : 4;
                    mis = (bus.d_size == 2'b11) || (a % n != 0);
                    if (mis) begin
                        chk("mis_ram_ctl", {27'd0, bus.ram_we, bus.ram_be}, 32'd0);
                        chk("mis_ram_addr", bus.ram_addr, 32'd0);
                        dq.push_back('{cyc + 1, 32'd0, 1'b1});
                    end else if (bus.d_we) begin
                        ebe = 4'b0000;
                        for (int k = 0; k < n; k++) ebe[(a % 4) + k] = 1'b1;
                        ed = (n == 1) ? {4{bus.d_wdata[7:0]}} :
                             (n == 2) ? {2{bus.d_wdata[15:0]}} : bus.d_wdata;
                        chk("st_ram_addr", bus.ram_addr, {bus.d_addr[31:2], 2'b00});
                        chk("st_ram_ctl", {27'd0, bus.ram_we, bus.ram_be}, {27'd0, 1'b1, ebe});
                        chk("st_ram_data", bus.ram_data_in, ed);
                        for (int k = 0; k < n; k++) mbytes[a + k] = bus.d_wdata[8*k +: 8];
                    end else begin
                        chk("ld_ram_addr", bus.ram_addr, {bus.d_addr[31:2], 2'b00});
                        chk("ld_ram_we", {31'd0, bus.ram_we}, 32'd0);
                        dq.push_back('{cyc + 1, model_load(a, bus.d_size, bus.d_unsigned), 1'b0});
                    end
                end else begin
                    chk("idle_ram_ctl", {27'd0, bus.ram_we, bus.ram_be}, 32'd0);
                    chk("idle_ram_addr", bus.ram_addr, 32'd0);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Drivers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic d_issue(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd);
        bit got = 0;
        bus.d_we = we; bus.d_size = sz; bus.d_unsigned = uns;
        bus.d_addr = a; bus.d_wdata = wd; bus.d_req = 1'b1;
        for (int t = 0; t < 64 && !got; t++) begin
            @(negedge clk); #1;
            if (bus.d_gnt) got = 1;
            else begin @(posedge clk); #1; end
        end
        if (!got) chk("d_gnt_timeout", 32'd0, 32'd1);
        else begin @(posedge clk); #1; end
        bus.d_req = 1'b0;
    endtask

    task automatic f_issue(input logic [31:0] a);
        bit got = 0;
        bus.if_addr = a; bus.if_req = 1'b1;
        for (int t = 0; t < 64 && !got; t++) begin
            @(negedge clk); #1;
            if (bus.if_gnt) got = 1;
            else begin @(posedge clk); #1; end
        end
        if (!got) chk("if_gnt_timeout", 32'd0, 32'd1);
        else begin @(posedge clk); #1; end
        bus.if_req = 1'b0;
    endtask

    task automatic d_random();
        int r;
        logic [1:0] sz;
        logic [31:0] a;
        r  = $urandom_range(0, 9);
        sz = (r < 3) ? SZ_B : (r < 6) ? SZ_H : (r < 9) ? SZ_W : 2'b11;
        a  = 32'($urandom_range(0, 255));
        if ($urandom_range(0, 3) != 0) begin
            if (sz == SZ_H) a[0]   = 1'b0;
            if (sz == SZ_W) a[1:0] = 2'b00;
        end
        d_issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    endtask

    initial begin : stimulus
        int f0, d0;
        bus.if_req = 0; bus.if_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_size = SZ_B; bus.d_unsigned = 0;
        bus.d_addr = '0; bus.d_wdata = '0;
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b1; ram_fill = 1'b0;
        @(posedge clk); #1;

        // Directed scenarios
        f_issue(32'h0000_0010);
        d_issue(1'b1, SZ_B, 1'b0, 32'h23, 32'h0000_00A5);
        d_issue(1'b0, SZ_W, 1'b0, 32'h20, 32'h0);
        d_issue(1'b1, SZ_W, 1'b0, 32'h20, 32'h8001_7FFF);
        d_issue(1'b0, SZ_H, 1'b0, 32'h22, 32'h0);
        d_issue(1'b0, SZ_H, 1'b1, 32'h22, 32'h0);
        d_issue(1'b0, SZ_B, 1'b0, 32'h23, 32'h0);
        d_issue(1'b0, SZ_W, 1'b0, 32'h41, 32'h0);
        d_issue(1'b1, SZ_H, 1'b0, 32'h43, 32'h1234);
        d_issue(1'b0, 2'b11, 1'b0, 32'h44, 32'h0);

        // Reset right after a load grant: its response must be dropped
        d_issue(1'b0, SZ_W, 1'b0, 32'h20, 32'h0);
        rst_n = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        @(posedge clk); #1;
        d_issue(1'b0, SZ_H, 1'b1, 32'h20, 32'h0);
        f_issue(32'h0000_0020);

        // Both requesters held continuously: 4 data grants per fetch grant
        @(posedge clk); #1;
        f0 = n_if_gnt; d0 = n_d_gnt;
        bus.if_addr = 32'h30; bus.if_req = 1'b1;
        bus.d_we = 1'b0; bus.d_size = SZ_W; bus.d_addr = 32'h40; bus.d_req = 1'b1;
        repeat (25) begin @(posedge clk); #1; end
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        chk("starve_fetch_grants", 32'(n_if_gnt - f0), 32'd5);
        chk("starve_data_grants", 32'(n_d_gnt - d0), 32'd20);

        // Randomized concurrent traffic
        fork
            begin
                repeat (500) begin
                    if ($urandom_range(0, 3) == 0)
                        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
                    d_random();
                end
            end
            begin
                repeat (300) begin
                    if ($urandom_range(0, 2) == 0)
                        repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
                    f_issue(32'($urandom_range(0, 255)));
                end
            end
        join

        repeat (4) begin @(posedge clk); #1; end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
